// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM state codes and the
// load-use hazard test.
package hazard_ctrl_pkg;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR      = 2'd2;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A load targeting $0 never creates a real dependency.
   function automatic logic load_use_hit(
      input logic       ex_memread,
      input logic [4:0] ex_rt,
      input logic [4:0] id_rs,
      input logic [4:0] id_rt
   );
      return ex_memread && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
   endfunction

endpackage

// File: rtl/hazard_ctrl_watchdog.sv
// Memory-wait watchdog: counts stalled MEM_WAIT cycles and flags the cycle in
// which the count would reach MEM_TIMEOUT.
module mem_watchdog #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 7
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic expired_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt <= '0;
      end else if (clr_i) begin
         cnt <= '0;
      end else if (inc_i) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // Expires in the cycle whose increment would land on MEM_TIMEOUT.
   assign expired_o = inc_i && (cnt == CNT_TC);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller for the 5-stage core.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state       | meaning
// ST_RUN      | pipeline flows; load-use bubbles and branch flushes apply
// ST_MEM_WAIT | MEM access outstanding, whole pipeline frozen, watchdog runs
// ST_ERR      | memory timeout, pipeline frozen until reset, err_o high
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 7
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  id_rs_i,
   input  logic [4:0]  id_rt_i,
   input  logic        ex_memread_i,
   input  logic [4:0]  ex_rt_i,
   input  logic        id_branch_taken_i,
   input  logic        mem_access_i,
   input  logic        mem_ready_i,
   output logic        pc_write_o,
   output logic        ifid_write_o,
   output logic        ifid_flush_o,
   output logic        idex_bubble_o,
   output logic        pipe_stall_o,
   output logic        err_o,
   output logic [31:0] perf_stall_cnt_o,
   output logic [31:0] perf_flush_cnt_o
);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       wd_expired;
   logic       mem_stall;
   logic       load_use;
   logic       br_flush;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:      if (mem_access_i && !mem_ready_i) state_nxt = ST_MEM_WAIT;
         ST_MEM_WAIT: if (mem_ready_i)                  state_nxt = ST_RUN;
                      else if (wd_expired)              state_nxt = ST_ERR;
         ST_ERR:      state_nxt = ST_ERR;
         default:     state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= ST_RUN;
      else        state <= state_nxt;
   end

   mem_watchdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc_i     (state == ST_MEM_WAIT),
      .clr_i     (state_nxt == ST_RUN),
      .expired_o (wd_expired)
   );

   // Priority: memory stall masks load-use, load-use masks the branch flush.
   assign mem_stall = (state != ST_RUN) || (mem_access_i && !mem_ready_i);
   assign load_use  = !mem_stall && load_use_hit(ex_memread_i, ex_rt_i, id_rs_i, id_rt_i);
   assign br_flush  = !mem_stall && !load_use && id_branch_taken_i;

   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_stall_o  = 1'b0;
      if (rst_i) begin
         if (mem_stall) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_stall_o = 1'b1;
         end else if (load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
         end else if (br_flush) begin
            ifid_flush_o = 1'b1;
         end
      end
   end

   assign err_o = (state == ST_ERR);

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (mem_stall || load_use) stall_cnt <= stall_cnt + 32'd1;
         if (br_flush)              flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt_o = stall_cnt;
   assign perf_flush_cnt_o = flush_cnt;
`else
   assign perf_stall_cnt_o = 32'd0;
   assign perf_flush_cnt_o = 32'd0;
`endif

endmodule
